// File: rtl/memwb_stage.sv
// memwb_stage: parametrised MEM/WB pipeline register with valid/ready handshake,
// flush, byte-offset load alignment, misalignment detection and a two-state FSM
// that parks a load until its data-memory response arrives.
//
// Optional feature: define MEMWB_FWD_EN to add the same-cycle forwarding outputs
// fwd_valid / fwd_rdn / fwd_rdd (combinational copies of next-edge rd_we/rdn/rdd).
//
// Ports:
//   clk, rstn          clock, asynchronous active-low reset
//   in_valid/in_ready  MEM-stage handshake (in_ready is combinational)
//   flush              kill the in-flight or incoming instruction
//   wbs                write-back select: 0 LB, 1 LH, 2 LW, 3 ALU, 4 LBU, 5 LHU
//   rdn_in, alu_out    destination register and ALU result
//   byte_off           load address low bits
//   mrd, mrd_valid     data-memory response
//   rdn, rdd, rd_we    registered register-file write port
//   misalign           one-cycle pulse when a misaligned load is suppressed
module memwb_stage #(
    parameter int unsigned WordSize    = 32,
    parameter int unsigned RegAddrBits = 5,
    parameter int unsigned OffBits     = $clog2(WordSize / 8)
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   flush,
    input  logic [2:0]             wbs,
    input  logic [RegAddrBits-1:0] rdn_in,
    input  logic [WordSize-1:0]    alu_out,
    input  logic [OffBits-1:0]     byte_off,
    input  logic [WordSize-1:0]    mrd,
    input  logic                   mrd_valid,
    output logic [RegAddrBits-1:0] rdn,
    output logic [WordSize-1:0]    rdd,
    output logic                   rd_we,
`ifdef MEMWB_FWD_EN
    output logic                   fwd_valid,
    output logic [RegAddrBits-1:0] fwd_rdn,
    output logic [WordSize-1:0]    fwd_rdd,
`endif
    output logic                   misalign
);

    localparam logic [2:0] WbsLb  = 3'd0;
    localparam logic [2:0] WbsLh  = 3'd1;
    localparam logic [2:0] WbsLw  = 3'd2;
    localparam logic [2:0] WbsAlu = 3'd3;
    localparam logic [2:0] WbsLbu = 3'd4;
    localparam logic [2:0] WbsLhu = 3'd5;

    typedef enum logic [0:0] {StIdle, StWait} state_e;

    state_e                 state_q, state_d;
    logic                   drop_q, drop_d;
    logic [2:0]             hold_wbs_q, hold_wbs_d;
    logic [RegAddrBits-1:0] hold_rdn_q, hold_rdn_d;
    logic [OffBits-1:0]     hold_off_q, hold_off_d;
    logic [RegAddrBits-1:0] rdn_q, rdn_d;
    logic [WordSize-1:0]    rdd_q, rdd_d;
    logic                   rd_we_q, rd_we_d;
    logic                   mis_q, mis_d;

    logic                   is_load;
    logic                   accept;
    logic                   retire;
    logic [2:0]             r_wbs;
    logic [RegAddrBits-1:0] r_rdn;
    logic [OffBits-1:0]     r_off;
    logic [15:0]            shifted16;
    logic [WordSize-1:0]    result;
    logic                   legal;
    logic                   mis;

    assign in_ready = (state_q == StIdle) && !drop_q;
    assign accept   = in_valid && in_ready && !flush;
    assign is_load  = (wbs == WbsLb) || (wbs == WbsLh) || (wbs == WbsLw) ||
                      (wbs == WbsLbu) || (wbs == WbsLhu);

    // Control: decide whether an instruction retires this cycle and which
    // fields (live inputs or held copies) describe it.
    always_comb begin
        state_d    = state_q;
        drop_d     = drop_q;
        hold_wbs_d = hold_wbs_q;
        hold_rdn_d = hold_rdn_q;
        hold_off_d = hold_off_q;
        retire     = 1'b0;
        r_wbs      = wbs;
        r_rdn      = rdn_in;
        r_off      = byte_off;
        unique case (state_q)
            StIdle: begin
                if (drop_q) begin
                    // Swallow the response of a flushed load.
                    if (mrd_valid) begin
                        drop_d = 1'b0;
                    end
                end else if (accept) begin
                    if (is_load && !mrd_valid) begin
                        state_d    = StWait;
                        hold_wbs_d = wbs;
                        hold_rdn_d = rdn_in;
                        hold_off_d = byte_off;
                    end else begin
                        retire = 1'b1;
                    end
                end
            end
            StWait: begin
                r_wbs = hold_wbs_q;
                r_rdn = hold_rdn_q;
                r_off = hold_off_q;
                if (flush) begin
                    // A response arriving with the flush is the one being killed.
                    state_d = StIdle;
                    drop_d  = !mrd_valid;
                end else if (mrd_valid) begin
                    state_d = StIdle;
                    retire  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Datapath: alignment, extension and misalignment for the retiring op.
    always_comb begin
        shifted16 = 16'(mrd >> {r_off, 3'b000});
        legal     = 1'b1;
        case (r_wbs)
            WbsLb:   result = {{(WordSize - 8){shifted16[7]}}, shifted16[7:0]};
            WbsLh:   result = {{(WordSize - 16){shifted16[15]}}, shifted16};
            WbsLw:   result = mrd;
            WbsAlu:  result = alu_out;
            WbsLbu:  result = {{(WordSize - 8){1'b0}}, shifted16[7:0]};
            WbsLhu:  result = {{(WordSize - 16){1'b0}}, shifted16};
            default: begin
                result = '0;
                legal  = 1'b0;
            end
        endcase
        mis = 1'b0;
        if (r_wbs == WbsLh || r_wbs == WbsLhu) begin
            mis = r_off[0] || (r_off == OffBits'(WordSize / 8 - 1));
        end else if (r_wbs == WbsLw) begin
            mis = (r_off != '0);
        end
    end

    // Next-edge write-port values; x0 keeps its data registered but never writes.
    always_comb begin
        rd_we_d = 1'b0;
        mis_d   = 1'b0;
        rdn_d   = rdn_q;
        rdd_d   = rdd_q;
        if (retire) begin
            if (mis) begin
                mis_d = 1'b1;
            end else begin
                rdn_d   = r_rdn;
                rdd_d   = result;
                rd_we_d = legal && (r_rdn != '0);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= StIdle;
            drop_q     <= 1'b0;
            hold_wbs_q <= '0;
            hold_rdn_q <= '0;
            hold_off_q <= '0;
            rdn_q      <= '0;
            rdd_q      <= '0;
            rd_we_q    <= 1'b0;
            mis_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            drop_q     <= drop_d;
            hold_wbs_q <= hold_wbs_d;
            hold_rdn_q <= hold_rdn_d;
            hold_off_q <= hold_off_d;
            rdn_q      <= rdn_d;
            rdd_q      <= rdd_d;
            rd_we_q    <= rd_we_d;
            mis_q      <= mis_d;
        end
    end

    assign rdn      = rdn_q;
    assign rdd      = rdd_q;
    assign rd_we    = rd_we_q;
    assign misalign = mis_q;

`ifdef MEMWB_FWD_EN
    assign fwd_valid = rd_we_d;
    assign fwd_rdn   = rdn_d;
    assign fwd_rdd   = rdd_d;
`endif

endmodule

// File: tb/tb_memwb_stage.sv
module tb_memwb_stage;

    logic        clk = 1'b0;
    logic        rstn;
    logic        in_valid;
    logic        in_ready;
    logic        flush;
    logic [2:0]  wbs;
    logic [4:0]  rdn_in;
    logic [31:0] alu_out;
    logic [1:0]  byte_off;
    logic [31:0] mrd;
    logic        mrd_valid;
    logic [4:0]  rdn;
    logic [31:0] rdd;
    logic        rd_we;
    logic        misalign;
`ifdef MEMWB_FWD_EN
    logic        fwd_valid;
    logic [4:0]  fwd_rdn;
    logic [31:0] fwd_rdd;
`endif

    memwb_stage #(
        .WordSize   (32),
        .RegAddrBits(5)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .flush    (flush),
        .wbs      (wbs),
        .rdn_in   (rdn_in),
        .alu_out  (alu_out),
        .byte_off (byte_off),
        .mrd      (mrd),
        .mrd_valid(mrd_valid),
        .rdn      (rdn),
        .rdd      (rdd),
        .rd_we    (rd_we),
`ifdef MEMWB_FWD_EN
        .fwd_valid(fwd_valid),
        .fwd_rdn  (fwd_rdn),
        .fwd_rdd  (fwd_rdd),
`endif
        .misalign (misalign)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic        mis;
        logic [4:0]  rdn;
        logic [31:0] rdd;
    } exp_t;

    exp_t        sb[$];
    int          n_assert = 0;
    int          n_fail = 0;
    logic [4:0]  m_rdn = '0;
    logic [31:0] m_rdd = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drv(input logic v, input logic fl, input logic [2:0] w, input logic [4:0] rn,
                       input logic [31:0] alu, input logic [1:0] off, input logic [31:0] md,
                       input logic mv);
        in_valid  = v;
        flush     = fl;
        wbs       = w;
        rdn_in    = rn;
        alu_out   = alu;
        byte_off  = off;
        mrd       = md;
        mrd_valid = mv;
    endtask

    task automatic idle();
        drv(1'b0, 1'b0, 3'd0, 5'd0, 32'd0, 2'd0, 32'd0, 1'b0);
    endtask

    // One clock: check in_ready now, queue the expected write port, compare after the edge.
    task automatic cyc(input string tag, input logic rdy, input logic we, input logic mis,
                       input logic [4:0] rn, input logic [31:0] rd);
        exp_t e;
        #1;
        chk({tag, "/in_ready"}, 32'(in_ready), 32'(rdy));
`ifdef MEMWB_FWD_EN
        chk({tag, "/fwd_valid"}, 32'(fwd_valid), 32'(we));
        chk({tag, "/fwd_rdn"}, 32'(fwd_rdn), 32'(rn));
        chk({tag, "/fwd_rdd"}, fwd_rdd, rd);
`endif
        m_rdn = rn;
        m_rdd = rd;
        e = '{we: we, mis: mis, rdn: rn, rdd: rd};
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({tag, "/rd_we"}, 32'(rd_we), 32'(e.we));
        chk({tag, "/misalign"}, 32'(misalign), 32'(e.mis));
        chk({tag, "/rdn"}, 32'(rdn), 32'(e.rdn));
        chk({tag, "/rdd"}, rdd, e.rdd);
    endtask

    initial begin
        rstn = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        chk("reset/rd_we", 32'(rd_we), 32'd0);
        chk("reset/misalign", 32'(misalign), 32'd0);
        chk("reset/rdn", 32'(rdn), 32'd0);
        chk("reset/rdd", rdd, 32'd0);
        chk("reset/in_ready", 32'(in_ready), 32'd1);
        rstn = 1'b1;

        // ALU op, then a bubble
        drv(1'b1, 1'b0, 3'd3, 5'd7, 32'h1234_5678, 2'd0, 32'd0, 1'b0);
        cyc("alu", 1'b1, 1'b1, 1'b0, 5'd7, 32'h1234_5678);
        idle();
        cyc("alu_after", 1'b1, 1'b0, 1'b0, m_rdn, m_rdd);

        // Loads with same-cycle response
        drv(1'b1, 1'b0, 3'd0, 5'd4, 32'd0, 2'd2, 32'h0080_0000, 1'b1);
        cyc("lb_off2", 1'b1, 1'b1, 1'b0, 5'd4, 32'hFFFF_FF80);
        drv(1'b1, 1'b0, 3'd4, 5'd5, 32'd0, 2'd2, 32'h0080_0000, 1'b1);
        cyc("lbu_off2", 1'b1, 1'b1, 1'b0, 5'd5, 32'h0000_0080);
        drv(1'b1, 1'b0, 3'd5, 5'd6, 32'd0, 2'd2, 32'hBEEF_0000, 1'b1);
        cyc("lhu_off2", 1'b1, 1'b1, 1'b0, 5'd6, 32'h0000_BEEF);
        drv(1'b1, 1'b0, 3'd0, 5'd14, 32'd0, 2'd3, 32'h7F00_0000, 1'b1);
        cyc("lb_off3", 1'b1, 1'b1, 1'b0, 5'd14, 32'h0000_007F);
        drv(1'b1, 1'b0, 3'd2, 5'd13, 32'd0, 2'd0, 32'hDEAD_BEEF, 1'b1);
        cyc("lw", 1'b1, 1'b1, 1'b0, 5'd13, 32'hDEAD_BEEF);

        // Delayed LH response; a competing ALU op and a new byte_off are ignored
        drv(1'b1, 1'b0, 3'd1, 5'd3, 32'd0, 2'd0, 32'd0, 1'b0);
        cyc("lh_accept", 1'b1, 1'b0, 1'b0, m_rdn, m_rdd);
        drv(1'b1, 1'b0, 3'd3, 5'd9, 32'hAAAA_AAAA, 2'd3, 32'd0, 1'b0);
        cyc("lh_wait1", 1'b0, 1'b0, 1'b0, m_rdn, m_rdd);
        cyc("lh_wait2", 1'b0, 1'b0, 1'b0, m_rdn, m_rdd);
        drv(1'b0, 1'b0, 3'd3, 5'd9, 32'hAAAA_AAAA, 2'd3, 32'h0000_8001, 1'b1);
        cyc("lh_resp", 1'b0, 1'b1, 1'b0, 5'd3, 32'hFFFF_8001);
        idle();
        cyc("lh_after", 1'b1, 1'b0, 1'b0, m_rdn, m_rdd);

        // Flush in WAIT, response arrives later and is dropped
        drv(1'b1, 1'b0, 3'd2, 5'd8, 32'd0, 2'd0, 32'd0, 1'b0);
        cyc("fl_accept", 1'b1, 1'b0, 1'b0, m_rdn, m_rdd);
        drv(1'b0, 1'b1, 3'd0, 5'd0, 32'd0, 2'd0, 32'd0, 1'b0);
        cyc("fl_flush", 1'b0, 1'b0, 1'b0, m_rdn, m_rdd);
        idle();
        cyc("fl_pending", 1'b0, 1'b0, 1'b0, m_rdn, m_rdd);
        drv(1'b0, 1'b0, 3'd0, 5'd0, 32'd0, 2'd0, 32'h5555_5555, 1'b1);
        cyc("fl_resp", 1'b0, 1'b0, 1'b0, m_rdn, m_rdd);
        idle();
        cyc("fl_after", 1'b1, 1'b0, 1'b0, m_rdn, m_rdd);

        // Flush in WAIT together with the response
        drv(1'b1, 1'b0, 3'd2, 5'd8, 32'd0, 2'd0, 32'd0, 1'b0);
        cyc("flr_accept", 1'b1, 1'b0, 1'b0, m_rdn, m_rdd);
        drv(1'b0, 1'b1, 3'd0, 5'd0, 32'd0, 2'd0, 32'h6666_6666, 1'b1);
        cyc("flr_flush", 1'b0, 1'b0, 1'b0, m_rdn, m_rdd);
        idle();
        cyc("flr_after", 1'b1, 1'b0, 1'b0, m_rdn, m_rdd);

        // Flush of an incoming ALU op in IDLE
        drv(1'b1, 1'b1, 3'd3, 5'd10, 32'h0BAD_F00D, 2'd0, 32'd0, 1'b0);
        cyc("fl_idle", 1'b1, 1'b0, 1'b0, m_rdn, m_rdd);

        // Misaligned loads
        drv(1'b1, 1'b0, 3'd1, 5'd11, 32'd0, 2'd1, 32'h1111_1111, 1'b1);
        cyc("lh_off1", 1'b1, 1'b0, 1'b1, m_rdn, m_rdd);
        idle();
        cyc("lh_off1_after", 1'b1, 1'b0, 1'b0, m_rdn, m_rdd);
        drv(1'b1, 1'b0, 3'd5, 5'd11, 32'd0, 2'd3, 32'h1111_1111, 1'b1);
        cyc("lhu_off3", 1'b1, 1'b0, 1'b1, m_rdn, m_rdd);
        drv(1'b1, 1'b0, 3'd2, 5'd11, 32'd0, 2'd2, 32'h1111_1111, 1'b1);
        cyc("lw_off2", 1'b1, 1'b0, 1'b1, m_rdn, m_rdd);

        // x0 destination and illegal select
        drv(1'b1, 1'b0, 3'd2, 5'd0, 32'd0, 2'd0, 32'hCAFE_BABE, 1'b1);
        cyc("lw_x0", 1'b1, 1'b0, 1'b0, 5'd0, 32'hCAFE_BABE);
        drv(1'b1, 1'b0, 3'd6, 5'd12, 32'hFFFF_FFFF, 2'd0, 32'hFFFF_FFFF, 1'b1);
        cyc("wbs6", 1'b1, 1'b0, 1'b0, 5'd12, 32'd0);

        // Stray response in IDLE
        drv(1'b0, 1'b0, 3'd2, 5'd1, 32'd0, 2'd0, 32'h7777_7777, 1'b1);
        cyc("stray_resp", 1'b1, 1'b0, 1'b0, m_rdn, m_rdd);

        // Reset while a load waits; the late response must not write
        drv(1'b1, 1'b0, 3'd2, 5'd15, 32'd0, 2'd0, 32'd0, 1'b0);
        cyc("rst_accept", 1'b1, 1'b0, 1'b0, m_rdn, m_rdd);
        idle();
        cyc("rst_wait", 1'b0, 1'b0, 1'b0, m_rdn, m_rdd);
        rstn = 1'b0;
        #1;
        chk("rst_mid/rd_we", 32'(rd_we), 32'd0);
        chk("rst_mid/misalign", 32'(misalign), 32'd0);
        chk("rst_mid/rdn", 32'(rdn), 32'd0);
        chk("rst_mid/rdd", rdd, 32'd0);
        chk("rst_mid/in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        drv(1'b0, 1'b0, 3'd0, 5'd0, 32'd0, 2'd0, 32'h9999_9999, 1'b1);
        cyc("rst_late_resp", 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        idle();
        cyc("rst_after", 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
